axi_dma_packet_gate: RTL
========================

Name: axi_dma_packet_gate

Overview:
Parametrised successor of the single-beat DMA gating slice. It sits between a packet-producing AXI-Stream source and the AXI DMA S2MM channel. It buffers beats in a FIFO and releases whole packets only while the block holds a DMA-rearm credit. Credits are granted by a configurable edge on the S2MM interrupt and saturate at a configurable maximum, so up to MAX_CREDITS packets may be queued ahead of software.

Parameters:
TDATA_WIDTH, 128, stream data width in bits; multiple of 8.
FIFO_DEPTH, 16, buffer depth in beats; power of 2, at least 2.
MAX_CREDITS, 4, credit counter saturation value; range 1..15.
INIT_CREDITS, 1, credit count after reset; at most MAX_CREDITS.
INTR_EDGE, 0, interrupt edge that grants a credit: 0 = falling (DMA interrupt cleared), 1 = rising.

Ports:
ACLK  in  1  clock
ARESETN  in  1  asynchronous active-low reset
S_AXIS_TDATA  in  TDATA_WIDTH  upstream data
S_AXIS_TKEEP  in  TDATA_WIDTH/8  upstream byte enables
S_AXIS_TLAST  in  1  upstream end of packet
S_AXIS_TVALID  in  1  upstream valid
S_AXIS_TREADY  out  1  upstream ready
M_AXIS_TDATA  out  TDATA_WIDTH  data to DMA
M_AXIS_TKEEP  out  TDATA_WIDTH/8  byte enables to DMA
M_AXIS_TLAST  out  1  end of packet to DMA
M_AXIS_TVALID  out  1  valid to DMA
M_AXIS_TREADY  in  1  DMA ready
AXIDMA_S2MM_INTR_IN  in  1  DMA S2MM interrupt, synchronous to ACLK
CLR_OVF  in  1  single-cycle pulse; clears CREDIT_OVF
CREDIT_COUNT  out  4  current credit count
FIFO_LEVEL  out  $clog2(FIFO_DEPTH)+1  beats currently buffered
PKT_COUNT  out  16  packets delivered, wraps
CREDIT_OVF  out  1  sticky flag: a credit was granted while the counter was saturated

Behaviour:
- Reset (ARESETN=0, asynchronous): FIFO empty; FIFO_LEVEL=0; CREDIT_COUNT=INIT_CREDITS; PKT_COUNT=0; CREDIT_OVF=0; M_AXIS_TVALID=0; M_AXIS_TLAST=0; M_AXIS_TDATA=0; M_AXIS_TKEEP=0; S_AXIS_TREADY=0. Reset mid-packet discards all buffered data; no partial-packet recovery.
- Write side: S_AXIS_TREADY = ARESETN_released & (FIFO_LEVEL < FIFO_DEPTH). A beat is written on S_AXIS_TVALID & S_AXIS_TREADY. When full, no write-through occurs, even if a read happens in the same cycle.
- FIFO is first-word-fall-through. A beat written in cycle N is presentable on M_AXIS in cycle N+1 at the earliest. M_AXIS_TDATA, TKEEP and TLAST always reflect the FIFO head; they are 0 when the FIFO is empty.
- Gate state machine, two states:
  - CLOSED (CREDIT_COUNT=0): M_AXIS_TVALID=0.
  - OPEN (CREDIT_COUNT>0): M_AXIS_TVALID = FIFO non-empty.
- Credits are consumed only on a handshake of a beat with TLAST=1. The gate therefore never closes mid-packet. The beat after TLAST is held while CREDIT_COUNT=0.
- Interrupt edge detect:
  - One register samples AXIDMA_S2MM_INTR_IN.
  - The register resets to 0 when INTR_EDGE=0 and to 1 when INTR_EDGE=1, so no spurious edge is seen after reset.
  - Edge = (prev=1 & cur=0) for INTR_EDGE=0; (prev=0 & cur=1) for INTR_EDGE=1.
- Credit update each cycle, where inc = edge and dec = TLAST handshake:
  - inc & dec: count unchanged.
  - inc only: count+1, saturating at MAX_CREDITS. If already at MAX_CREDITS, set CREDIT_OVF.
  - dec only: count-1. Cannot underflow, because TVALID=0 when count=0.
- CREDIT_OVF: the set condition has priority over CLR_OVF in the same cycle.
- PKT_COUNT increments by 1 on each TLAST handshake, modulo 2^16.
- A packet longer than FIFO_DEPTH streams through normally, since the gate only blocks at packet boundaries.
- Steady state with credits available and M_AXIS_TREADY=1: one beat per cycle, no bubbles.

Decomposition:
- Shared package/header axi_dma_pkg holds INTR_EDGE_FALLING=0, INTR_EDGE_RISING=1, and the credit counter width constant CREDIT_W=4.
- One sub-module, axis_fwft_fifo (parameters WIDTH, DEPTH; ports ACLK/ARESETN, wr_en, din, full, rd_en, dout, empty, level). The FIFO stores {TLAST, TKEEP, TDATA} packed into WIDTH = TDATA_WIDTH + TDATA_WIDTH/8 + 1.
- Gate, credit and counter logic stays in the top level.

Test Plan:
- Reset defaults, INIT_CREDITS=1: push a 4-beat packet with TDATA 1..4 and TREADY=1 -> M beats 1..4 appear starting 1 cycle after the first write; TLAST on beat 4; CREDIT_COUNT 1->0; PKT_COUNT=1.
- Credit gating: with credits=0, push a second packet -> M_AXIS_TVALID stays 0 and FIFO_LEVEL=4. Drive the interrupt 1->0 -> TVALID rises the cycle after the edge is registered; the packet is delivered; credits return to 0.
- Saturation: with MAX_CREDITS=4, apply 6 falling edges with no traffic -> CREDIT_COUNT=4 and CREDIT_OVF=1. Pulse CLR_OVF -> CREDIT_OVF=0; a same-cycle edge at saturation keeps CREDIT_OVF=1.
- Simultaneous events: the interrupt edge lands in the same cycle as a TLAST handshake with credits=2 -> CREDIT_COUNT stays 2.
- Backpressure/full with FIFO_DEPTH=16: hold M_AXIS_TREADY=0 and stream 20 beats -> S_AXIS_TREADY drops after 16 accepted beats, FIFO_LEVEL=16. Release TREADY -> all 20 beats delivered in order, TKEEP preserved, no loss.
- Async reset mid-packet: assert ARESETN=0 after 2 of 4 beats -> outputs go to reset values immediately; FIFO_LEVEL=0; CREDIT_COUNT=INIT_CREDITS. The next full packet after reset is delivered intact.

Source files
------------

// File: rtl/axi_dma_pkg.sv
// Shared constants and types for the DMA packet gate.
package axi_dma_pkg;

  localparam int INTR_EDGE_FALLING = 0;
  localparam int INTR_EDGE_RISING  = 1;
  localparam int CREDIT_W          = 4;

  typedef enum logic {
    GATE_CLOSED = 1'b0,
    GATE_OPEN   = 1'b1
  } gate_state_e;

endpackage

// File: rtl/axis_fwft_fifo.sv
// First-word-fall-through FIFO; dout is zero while empty.
module axis_fwft_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     ACLK,
  input  logic                     ARESETN,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         din,
  output logic                     full,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_wr;
  logic             do_rd;

  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);
  assign level = cnt;
  assign do_wr = wr_en & ~full;
  assign do_rd = rd_en & ~empty;
  assign dout  = empty ? '0 : mem[rd_ptr];

  // Storage write; contents need no reset since dout is masked while empty.
  always_ff @(posedge ACLK) begin
    if (do_wr) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/axi_dma_packet_gate.sv
// Buffers AXI-Stream packets and releases whole packets only while a
// DMA-rearm credit is held; credits come from an S2MM interrupt edge.
module axi_dma_packet_gate
  import axi_dma_pkg::*;
#(
  parameter int TDATA_WIDTH  = 128,
  parameter int FIFO_DEPTH   = 16,
  parameter int MAX_CREDITS  = 4,
  parameter int INIT_CREDITS = 1,
  parameter int INTR_EDGE    = 0
) (
  input  logic                         ACLK,
  input  logic                         ARESETN,
  input  logic [TDATA_WIDTH-1:0]       S_AXIS_TDATA,
  input  logic [TDATA_WIDTH/8-1:0]     S_AXIS_TKEEP,
  input  logic                         S_AXIS_TLAST,
  input  logic                         S_AXIS_TVALID,
  output logic                         S_AXIS_TREADY,
  output logic [TDATA_WIDTH-1:0]       M_AXIS_TDATA,
  output logic [TDATA_WIDTH/8-1:0]     M_AXIS_TKEEP,
  output logic                         M_AXIS_TLAST,
  output logic                         M_AXIS_TVALID,
  input  logic                         M_AXIS_TREADY,
  input  logic                         AXIDMA_S2MM_INTR_IN,
  input  logic                         CLR_OVF,
  output logic [3:0]                   CREDIT_COUNT,
  output logic [$clog2(FIFO_DEPTH):0]  FIFO_LEVEL,
  output logic [15:0]                  PKT_COUNT,
  output logic                         CREDIT_OVF
);

  localparam int KW = TDATA_WIDTH / 8;
  localparam int FW = TDATA_WIDTH + KW + 1;
  localparam logic [CREDIT_W-1:0] MAX_C  = CREDIT_W'(MAX_CREDITS);
  localparam logic [CREDIT_W-1:0] INIT_C = CREDIT_W'(INIT_CREDITS);
  localparam logic INTR_RST = (INTR_EDGE == INTR_EDGE_RISING) ? 1'b1 : 1'b0;

  logic [FW-1:0]       fifo_din;
  logic [FW-1:0]       fifo_dout;
  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_rd;
  logic                fifo_wr;
  logic                intr_prev;
  logic                credit_inc;
  logic                credit_dec;
  logic [CREDIT_W-1:0] credit_q;
  logic [CREDIT_W-1:0] credit_d;
  logic                ovf_q;
  logic [15:0]         pkt_q;
  gate_state_e         state_q;
  gate_state_e         state_d;

  assign fifo_din      = {S_AXIS_TLAST, S_AXIS_TKEEP, S_AXIS_TDATA};
  assign S_AXIS_TREADY = ARESETN & ~fifo_full;
  assign fifo_wr       = S_AXIS_TVALID & S_AXIS_TREADY;
  assign fifo_rd       = M_AXIS_TVALID & M_AXIS_TREADY;

  axis_fwft_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .wr_en   (fifo_wr),
    .din     (fifo_din),
    .full    (fifo_full),
    .rd_en   (fifo_rd),
    .dout    (fifo_dout),
    .empty   (fifo_empty),
    .level   (FIFO_LEVEL)
  );

  assign {M_AXIS_TLAST, M_AXIS_TKEEP, M_AXIS_TDATA} = fifo_dout;

  assign credit_dec = fifo_rd & M_AXIS_TLAST;
  assign credit_inc = (INTR_EDGE == INTR_EDGE_RISING) ? (~intr_prev &  AXIDMA_S2MM_INTR_IN)
                                                      : ( intr_prev & ~AXIDMA_S2MM_INTR_IN);

  // Interrupt sampler; reset level matches the idle level so no edge follows reset.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) intr_prev <= INTR_RST;
    else          intr_prev <= AXIDMA_S2MM_INTR_IN;
  end

  // Next credit count: simultaneous grant and consume cancel out.
  always_comb begin
    credit_d = credit_q;
    if (credit_inc && !credit_dec) begin
      if (credit_q != MAX_C) credit_d = credit_q + 1'b1;
    end else if (credit_dec && !credit_inc) begin
      credit_d = credit_q - 1'b1;
    end
  end

  // Credit, overflow flag and packet counter registers.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      credit_q <= INIT_C;
      ovf_q    <= 1'b0;
      pkt_q    <= '0;
    end else begin
      credit_q <= credit_d;
      if (credit_inc && !credit_dec && credit_q == MAX_C) ovf_q <= 1'b1;
      else if (CLR_OVF)                                  ovf_q <= 1'b0;
      if (credit_dec) pkt_q <= pkt_q + 1'b1;
    end
  end

  // Gate state register; tracks whether the registered credit count is non-zero.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state_q <= (INIT_CREDITS != 0) ? GATE_OPEN : GATE_CLOSED;
    else          state_q <= state_d;
  end

  // Gate next state follows the next credit count.
  always_comb begin
    state_d = (credit_d != '0) ? GATE_OPEN : GATE_CLOSED;
  end

  // Gate output: present the FIFO head only while open.
  always_comb begin
    M_AXIS_TVALID = 1'b0;
    if (state_q == GATE_OPEN) M_AXIS_TVALID = ~fifo_empty;
  end

  assign CREDIT_COUNT = credit_q;
  assign CREDIT_OVF   = ovf_q;
  assign PKT_COUNT    = pkt_q;

endmodule
